// File: rtl/bullet_pkg.sv
// -----------------------------------------------------------------------------
// bullet_pkg
// Shared definitions for the bullet subsystem: direction command codes, the
// per-player fire channel state encoding, playfield size and a small helper
// that tells a real joystick direction apart from neutral/illegal codes.
// No ports (package).
// -----------------------------------------------------------------------------
package bullet_pkg;

    typedef logic [2:0] dir_t;

    localparam dir_t NEUTRAL = 3'd0;
    localparam dir_t RIGHT   = 3'd1;
    localparam dir_t LEFT    = 3'd2;
    localparam dir_t UP      = 3'd3;
    localparam dir_t DOWN    = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        COOLDOWN
    } chan_state_t;

    localparam int BOX_DIM = 90;

    // True only for the four codes a bullet can actually travel in.
    function automatic logic is_move(input dir_t d);
        return (d >= RIGHT) && (d <= DOWN);
    endfunction

endpackage

// File: rtl/fire_ctrl_if.sv
// -----------------------------------------------------------------------------
// fire_ctrl_if
// Frame-domain signal bundle between the input synchronisers / bullet manager
// (master side) and fire_ctrl (slave side).
//   master drives : nf_in, fire_in, b/c/d_dir_in, dead_in
//   slave drives  : b/c/d_bullet_out, ready_out, frozen_out, b/c/d_hits_out
// -----------------------------------------------------------------------------
interface fire_ctrl_if;
    import bullet_pkg::*;

    logic       nf_in;
    logic [2:0] fire_in;
    dir_t       b_dir_in;
    dir_t       c_dir_in;
    dir_t       d_dir_in;
    logic [1:0] dead_in;

    dir_t       b_bullet_out;
    dir_t       c_bullet_out;
    dir_t       d_bullet_out;
    logic [2:0] ready_out;
    logic       frozen_out;
    logic [3:0] b_hits_out;
    logic [3:0] c_hits_out;
    logic [3:0] d_hits_out;

    modport master (
        output nf_in, fire_in, b_dir_in, c_dir_in, d_dir_in, dead_in,
        input  b_bullet_out, c_bullet_out, d_bullet_out,
        input  ready_out, frozen_out, b_hits_out, c_hits_out, d_hits_out
    );

    modport slave (
        input  nf_in, fire_in, b_dir_in, c_dir_in, d_dir_in, dead_in,
        output b_bullet_out, c_bullet_out, d_bullet_out,
        output ready_out, frozen_out, b_hits_out, c_hits_out, d_hits_out
    );

endinterface

// File: rtl/fire_channel.sv
// -----------------------------------------------------------------------------
// fire_channel
// One player's fire path: facing register, fire-button edge detector, pending
// press flag, IDLE/ARMED/COOLDOWN state machine and refire cooldown counter.
// Ports:
//   clk_in, rst_in  : clock, asynchronous active-low reset
//   nf_in           : new-frame strobe (one cycle)
//   fire_in         : synchronised fire button
//   dir_in          : joystick direction code
//   frozen          : freeze counter currently nonzero (blocks new shots)
//   frozen_next     : freeze counter will be nonzero after this edge
//   flush           : hit on this frame; return to IDLE, drop everything
//   bullet_out      : registered direction command, one frame per shot
//   ready_out       : registered "IDLE and not frozen"
// -----------------------------------------------------------------------------
module fire_channel
    import bullet_pkg::*;
#(
    parameter int   COOLDOWN_FRAMES = 4,
    parameter dir_t RESET_FACING    = RIGHT
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic nf_in,
    input  logic fire_in,
    input  dir_t dir_in,
    input  logic frozen,
    input  logic frozen_next,
    input  logic flush,
    output dir_t bullet_out,
    output logic ready_out
);

    chan_state_t state;
    dir_t        facing;
    logic        fire_q;
    logic        pending;
    logic [7:0]  cnt;
    logic        fire_edge;

    assign fire_edge = fire_in && !fire_q;

    // NOTE: every register below is written with <= so all of them update
    // from the same pre-edge values, whatever order the statements are in.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state      <= IDLE;
            facing     <= RESET_FACING;
            fire_q     <= 1'b0;
            pending    <= 1'b0;
            cnt        <= 8'd0;
            bullet_out <= NEUTRAL;
            ready_out  <= 1'b1;
        end else begin
            fire_q <= fire_in;
            if (is_move(dir_in)) begin
                facing <= dir_in;
            end

            if (nf_in) begin
                pending <= 1'b0;
                if (flush) begin
                    state      <= IDLE;
                    bullet_out <= NEUTRAL;
                    cnt        <= 8'd0;
                    ready_out  <= !frozen_next;
                end else begin
                    case (state)
                        IDLE: begin
                            // A press latched earlier in the frame or one
                            // arriving on the tick itself both fire now.
                            if (!frozen && (pending || fire_edge)) begin
                                state      <= ARMED;
                                bullet_out <= facing;
                                ready_out  <= 1'b0;
                            end else begin
                                ready_out  <= !frozen_next;
                            end
                        end
                        ARMED: begin
                            state      <= COOLDOWN;
                            bullet_out <= NEUTRAL;
                            cnt        <= 8'(COOLDOWN_FRAMES);
                            ready_out  <= 1'b0;
                        end
                        COOLDOWN: begin
                            // Leaving cooldown takes the whole tick; a press
                            // is only accepted from the next frame on.
                            if (cnt == 8'd1) begin
                                state     <= IDLE;
                                cnt       <= 8'd0;
                                ready_out <= !frozen_next;
                            end else begin
                                cnt       <= cnt - 8'd1;
                                ready_out <= 1'b0;
                            end
                        end
                        default: begin
                            state      <= IDLE;
                            bullet_out <= NEUTRAL;
                            cnt        <= 8'd0;
                            ready_out  <= !frozen_next;
                        end
                    endcase
                end
            end else if (fire_edge && (state == IDLE) && !frozen) begin
                // Presses while busy or frozen are dropped, never queued.
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fire_ctrl.sv
// -----------------------------------------------------------------------------
// fire_ctrl
// Turns per-player fire buttons and joystick directions into one-frame bullet
// direction commands for the bullet manager, with per-player refire cooldown.
// A hit reported by the manager (dead_in) flushes all channels, freezes firing
// for FREEZE_FRAMES frames and bumps the victim's saturating hit counter.
// Ports:
//   clk_in, rst_in : clock, asynchronous active-low reset
//   bus (slave)    : nf_in, fire_in, b/c/d_dir_in, dead_in in;
//                    b/c/d_bullet_out, ready_out, frozen_out, b/c/d_hits_out out
// -----------------------------------------------------------------------------
module fire_ctrl
    import bullet_pkg::*;
#(
    parameter int COOLDOWN_FRAMES = 4,
    parameter int FREEZE_FRAMES   = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    fire_ctrl_if.slave  bus
);

    logic [7:0] freeze_cnt;
    logic       frozen;
    logic       frozen_next;
    logic       frozen_q;
    logic       hit;
    logic [3:0] hits [3];
    logic [2:0] ready;
    dir_t       b_bullet;
    dir_t       c_bullet;
    dir_t       d_bullet;

    assign hit    = bus.nf_in && (bus.dead_in != 2'd0);
    assign frozen = (freeze_cnt != 8'd0);

    // Channels need the post-edge freeze state so their ready flags switch on
    // the same edge as the freeze counter.
    // NOTE: default assignment first keeps this purely combinational.
    always_comb begin
        frozen_next = frozen;
        if (hit) begin
            frozen_next = 1'b1;
        end else if (bus.nf_in && frozen) begin
            frozen_next = (freeze_cnt != 8'd1);
        end
    end

    // NOTE: the hit counters are architectural outputs, so the array is
    // reset like any other register rather than left as uninitialised storage.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            freeze_cnt <= 8'd0;
            frozen_q   <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                hits[i] <= 4'd0;
            end
        end else begin
            frozen_q <= frozen_next;
            if (hit) begin
                // A hit during an active freeze restarts the full interval.
                freeze_cnt <= 8'(FREEZE_FRAMES);
                for (int i = 0; i < 3; i++) begin
                    if ((bus.dead_in == 2'(i + 1)) && (hits[i] != 4'hf)) begin
                        hits[i] <= hits[i] + 4'd1;
                    end
                end
            end else if (bus.nf_in && frozen) begin
                freeze_cnt <= freeze_cnt - 8'd1;
            end
        end
    end

    fire_channel #(.COOLDOWN_FRAMES(COOLDOWN_FRAMES), .RESET_FACING(RIGHT)) u_chan_b (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .nf_in       (bus.nf_in),
        .fire_in     (bus.fire_in[0]),
        .dir_in      (bus.b_dir_in),
        .frozen      (frozen),
        .frozen_next (frozen_next),
        .flush       (hit),
        .bullet_out  (b_bullet),
        .ready_out   (ready[0])
    );

    fire_channel #(.COOLDOWN_FRAMES(COOLDOWN_FRAMES), .RESET_FACING(LEFT)) u_chan_c (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .nf_in       (bus.nf_in),
        .fire_in     (bus.fire_in[1]),
        .dir_in      (bus.c_dir_in),
        .frozen      (frozen),
        .frozen_next (frozen_next),
        .flush       (hit),
        .bullet_out  (c_bullet),
        .ready_out   (ready[1])
    );

    fire_channel #(.COOLDOWN_FRAMES(COOLDOWN_FRAMES), .RESET_FACING(DOWN)) u_chan_d (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .nf_in       (bus.nf_in),
        .fire_in     (bus.fire_in[2]),
        .dir_in      (bus.d_dir_in),
        .frozen      (frozen),
        .frozen_next (frozen_next),
        .flush       (hit),
        .bullet_out  (d_bullet),
        .ready_out   (ready[2])
    );

    assign bus.b_bullet_out = b_bullet;
    assign bus.c_bullet_out = c_bullet;
    assign bus.d_bullet_out = d_bullet;
    assign bus.ready_out    = ready;
    assign bus.frozen_out   = frozen_q;
    assign bus.b_hits_out   = hits[0];
    assign bus.c_hits_out   = hits[1];
    assign bus.d_hits_out   = hits[2];

endmodule

// File: tb/tb_fire_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fire_ctrl
// Self-checking bench for fire_ctrl. The reference model works in frame-tick
// arithmetic: a player may fire on tick k when it last fired at or before
// k - COOLDOWN_FRAMES - 2 and the last hit was at or before k - FREEZE_FRAMES - 1.
// -----------------------------------------------------------------------------
module tb_fire_ctrl;
    import bullet_pkg::*;

    localparam int C = 4;
    localparam int F = 8;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    always #5 clk_in = ~clk_in;

    fire_ctrl_if bus();

    fire_ctrl #(.COOLDOWN_FRAMES(C), .FREEZE_FRAMES(F)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int         m_tick;
    int         m_last_arm [3];
    int         m_hit_tick;
    bit         m_edge_seen [3];
    bit         m_prev_fire [3];
    logic [2:0] m_facing [3];
    logic [2:0] m_shot [3];
    int         m_hits [3];
    logic [2:0] dir_hold [3];

    task automatic model_reset();
        m_tick     = 0;
        m_hit_tick = -1000;
        for (int i = 0; i < 3; i++) begin
            m_last_arm[i]  = -1000;
            m_edge_seen[i] = 1'b0;
            m_prev_fire[i] = 1'b0;
            m_shot[i]      = 3'd0;
            m_hits[i]      = 0;
        end
        m_facing[0] = 3'd1;
        m_facing[1] = 3'd2;
        m_facing[2] = 3'd4;
    endtask

    task automatic model_cycle(input logic nf, input logic [2:0] fire, input logic [1:0] dead);
        for (int i = 0; i < 3; i++) begin
            bit idle;
            bit frz;
            idle = (m_tick >= m_last_arm[i] + C + 1);
            frz  = (m_tick < m_hit_tick + F);
            if (fire[i] && !m_prev_fire[i] && idle && !frz) m_edge_seen[i] = 1'b1;
        end
        if (nf) begin
            m_tick++;
            if (dead != 2'd0) begin
                m_hit_tick = m_tick;
                for (int i = 0; i < 3; i++) m_last_arm[i] = -1000;
                if (m_hits[int'(dead) - 1] < 15) m_hits[int'(dead) - 1]++;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (m_edge_seen[i]) begin
                        m_last_arm[i] = m_tick;
                        m_shot[i]     = m_facing[i];
                    end
                end
            end
            for (int i = 0; i < 3; i++) m_edge_seen[i] = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            m_prev_fire[i] = fire[i];
            if (dir_hold[i] >= 3'd1 && dir_hold[i] <= 3'd4) m_facing[i] = dir_hold[i];
        end
    endtask

    function automatic logic [24:0] model_vec();
        logic [2:0] bl [3];
        logic [2:0] rdy;
        logic       frz;
        frz = (m_tick < m_hit_tick + F);
        for (int i = 0; i < 3; i++) begin
            bl[i]  = (m_last_arm[i] == m_tick) ? m_shot[i] : 3'd0;
            rdy[i] = (m_tick >= m_last_arm[i] + C + 1) && !frz;
        end
        return {bl[0], bl[1], bl[2], rdy, frz,
                4'(m_hits[0]), 4'(m_hits[1]), 4'(m_hits[2])};
    endfunction

    function automatic logic [24:0] dut_vec();
        return {bus.b_bullet_out, bus.c_bullet_out, bus.d_bullet_out, bus.ready_out,
                bus.frozen_out, bus.b_hits_out, bus.c_hits_out, bus.d_hits_out};
    endfunction

    // One clock: drive on the falling edge, update the model at the rising
    // edge, leave the caller 1 time unit after it to sample.
    task automatic step(input logic nf, input logic [2:0] fire, input logic [1:0] dead);
        @(negedge clk_in);
        bus.nf_in    = nf;
        bus.fire_in  = fire;
        bus.b_dir_in = dir_hold[0];
        bus.c_dir_in = dir_hold[1];
        bus.d_dir_in = dir_hold[2];
        bus.dead_in  = dead;
        @(posedge clk_in);
        model_cycle(nf, fire, dead);
        #1;
    endtask

    // One frame: press pulse three cycles before the tick, tick on the fourth.
    task automatic run_frame(input logic [2:0] press, input logic [1:0] dead);
        step(1'b0, press, 2'd0);
        step(1'b0, 3'b000, 2'd0);
        step(1'b0, 3'b000, 2'd0);
        step(1'b1, 3'b000, dead);
    endtask

    task automatic apply_reset();
        rst_in = 1'b0;
        bus.nf_in = 1'b0;
        bus.fire_in = 3'b000;
        bus.dead_in = 2'd0;
        for (int i = 0; i < 3; i++) dir_hold[i] = 3'd0;
        bus.b_dir_in = 3'd0;
        bus.c_dir_in = 3'd0;
        bus.d_dir_in = 3'd0;
        model_reset();
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        vectors++;
        if (dut_vec() !== 25'h0_0e_000 >> 0 && dut_vec() !== {9'd0, 3'b111, 1'b0, 12'd0}) begin
            miscompares++;
            $display("FAIL reset_state: got %h expected %h", dut_vec(), {9'd0, 3'b111, 1'b0, 12'd0});
        end
        vectors++;
        if (dut_vec() !== model_vec()) begin
            miscompares++;
            $display("FAIL reset_model: got %h expected %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_basic_fire_and_refire();
        apply_reset();
        for (int k = 1; k <= 8; k++) begin
            logic [2:0] exp_b;
            logic       exp_r;
            run_frame((k == 1 || k >= 2) ? 3'b001 : 3'b000, 2'd0);
            exp_b = (k == 1 || k == 7) ? 3'd1 : 3'd0;
            exp_r = (k >= 6 && k < 7);
            vectors++;
            if (bus.b_bullet_out !== exp_b || bus.ready_out[0] !== exp_r) begin
                miscompares++;
                $display("FAIL basic_refire tick %0d: got bullet %0d ready %b expected bullet %0d ready %b",
                         k, bus.b_bullet_out, bus.ready_out[0], exp_b, exp_r);
            end
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL basic_refire_model tick %0d: got %h expected %h", k, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_facing();
        apply_reset();
        dir_hold[1] = 3'd3;
        run_frame(3'b000, 2'd0);
        dir_hold[1] = 3'd0;
        run_frame(3'b000, 2'd0);
        dir_hold[1] = 3'd6;
        run_frame(3'b010, 2'd0);
        vectors++;
        if (bus.c_bullet_out !== UP) begin
            miscompares++;
            $display("FAIL facing_up: got %0d expected %0d", bus.c_bullet_out, UP);
        end
        vectors++;
        if (dut_vec() !== model_vec()) begin
            miscompares++;
            $display("FAIL facing_model: got %h expected %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_hit_freeze();
        apply_reset();
        for (int k = 1; k <= 9; k++) run_frame((k == 9) ? 3'b100 : 3'b000, 2'd0);
        vectors++;
        if (bus.d_bullet_out !== DOWN) begin
            miscompares++;
            $display("FAIL freeze_d_armed: got %0d expected %0d", bus.d_bullet_out, DOWN);
        end
        run_frame(3'b000, 2'd2);
        vectors++;
        if (bus.d_bullet_out !== NEUTRAL || bus.c_hits_out !== 4'd1 || bus.frozen_out !== 1'b1) begin
            miscompares++;
            $display("FAIL freeze_hit: got d %0d chits %0d frozen %b expected 0 1 1",
                     bus.d_bullet_out, bus.c_hits_out, bus.frozen_out);
        end
        for (int k = 11; k <= 19; k++) begin
            logic [8:0] exp_bl;
            run_frame(3'b111, 2'd0);
            exp_bl = (k == 19) ? {RIGHT, LEFT, DOWN} : 9'd0;
            vectors++;
            if ({bus.b_bullet_out, bus.c_bullet_out, bus.d_bullet_out} !== exp_bl ||
                bus.frozen_out !== (k <= 17)) begin
                miscompares++;
                $display("FAIL freeze_window tick %0d: got %h frozen %b expected %h frozen %b",
                         k, {bus.b_bullet_out, bus.c_bullet_out, bus.d_bullet_out},
                         bus.frozen_out, exp_bl, (k <= 17));
            end
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL freeze_model tick %0d: got %h expected %h", k, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_simultaneous_and_saturation();
        apply_reset();
        step(1'b0, 3'b000, 2'd0);
        step(1'b1, 3'b001, 2'd1);
        vectors++;
        if (bus.b_bullet_out !== NEUTRAL || bus.b_hits_out !== 4'd1) begin
            miscompares++;
            $display("FAIL simultaneous: got bullet %0d hits %0d expected 0 1",
                     bus.b_bullet_out, bus.b_hits_out);
        end
        for (int n = 2; n <= 17; n++) begin
            run_frame(3'b000, 2'd1);
            vectors++;
            if (bus.b_hits_out !== 4'((n > 15) ? 15 : n)) begin
                miscompares++;
                $display("FAIL hit_saturate n=%0d: got %0d expected %0d",
                         n, bus.b_hits_out, (n > 15) ? 15 : n);
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        run_frame(3'b001, 2'd0);
        vectors++;
        if (bus.b_bullet_out !== RIGHT) begin
            miscompares++;
            $display("FAIL areset_armed: got %0d expected %0d", bus.b_bullet_out, RIGHT);
        end
        @(negedge clk_in);
        #2;
        rst_in = 1'b0;
        #1;
        vectors++;
        if (bus.b_bullet_out !== NEUTRAL || bus.ready_out !== 3'b111) begin
            miscompares++;
            $display("FAIL areset_immediate: got bullet %0d ready %b expected 0 111",
                     bus.b_bullet_out, bus.ready_out);
        end
        model_reset();
        @(negedge clk_in);
        rst_in = 1'b1;
        run_frame(3'b001, 2'd0);
        vectors++;
        if (dut_vec() !== model_vec() || bus.b_bullet_out !== RIGHT) begin
            miscompares++;
            $display("FAIL areset_release: got %h expected %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_random();
        logic       nf;
        logic       prev_nf;
        logic [2:0] fire;
        logic [1:0] dead;
        apply_reset();
        prev_nf = 1'b0;
        fire    = 3'b000;
        for (int n = 0; n < 800; n++) begin
            nf = !prev_nf && ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) fire = 3'($urandom);
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 7) == 0) dir_hold[i] = 3'($urandom);
            end
            dead = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            step(nf, fire, dead);
            prev_nf = nf;
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL random cycle %0d tick %0d: got %h expected %h",
                         n, m_tick, dut_vec(), model_vec());
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic_fire_and_refire();
        test_facing();
        test_hit_freeze();
        test_simultaneous_and_saturation();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fire_ctrl.md
# fire_ctrl

Command-side source for the bullet subsystem: converts per-player fire buttons and joystick directions into the 3-bit bullet direction commands consumed by the bullet manager. The command codes are NEUTRAL, RIGHT, LEFT, UP and DOWN. The block enforces one-frame command pulses and a per-player refire cooldown. It also consumes the manager's `dead` code, freezing all firing for a round-over interval and counting hits per player. It sits between input synchronisers and the bullet manager, clocked on the frame-tick (`nf_in`) domain.

## Interface
- `COOLDOWN_FRAMES`, default 4: frames a player spends in cooldown after a shot; range 1..255.
- `FREEZE_FRAMES`, default 8: frames all firing is blocked after a hit; range 1..255.
- `clk_in` in 1: system clock.
- `rst_in` in 1: reset, asynchronous assert, active-low.
- `nf_in` in 1: new-frame strobe, one `clk_in` cycle wide.
- `fire_in` in 3: synchronised fire buttons, one per player: bit0 = b, bit1 = c, bit2 = d.
- `b_dir_in`, `c_dir_in`, `d_dir_in` in 3 each: joystick direction code for each player.
- `dead_in` in 2: hit code. 0 = none, 1 = b hit, 2 = c hit, 3 = d hit.
- `b_bullet_out`, `c_bullet_out`, `d_bullet_out` out 3 each: bullet direction commands.
- `ready_out` out 3: per-player flag, set when the channel is IDLE and not frozen.
- `frozen_out` out 1: set while the freeze counter is nonzero.
- `b_hits_out`, `c_hits_out`, `d_hits_out` out 4 each: times each player was hit, saturating.

## Operation
- **Per-player channel FSM states:** IDLE, ARMED, COOLDOWN.
- **Facing register:**
  - Updated every `clk_in` cycle when the direction input is 1..4.
  - Codes 0 and 5..7 are ignored.
  - Reset values: b = RIGHT, c = LEFT, d = DOWN.
- **Pending flag:**
  - Set on a rising edge of `fire_in[i]` (edge register reset to 0) while the channel is IDLE and not frozen.
  - Cleared on every `nf_in`.
  - Presses in ARMED, COOLDOWN or freeze are discarded, not queued.
- **IDLE → ARMED:** on `nf_in` when the press is pending, or the edge occurs in the same cycle. The output is loaded with the current facing.
- **ARMED → COOLDOWN:** on the next `nf_in`. The output returns to NEUTRAL and the counter is loaded with `COOLDOWN_FRAMES`.
- **COOLDOWN:** the counter decrements on each `nf_in`. On the `nf_in` where it reads 1, the channel goes to IDLE. A pending press is not accepted on that same tick.
- **Hit handling:** when `nf_in` arrives with `dead_in` ≠ 0:
  - All channels are forced to IDLE, all outputs to NEUTRAL, and all pending flags and cooldown counters are cleared.
  - The freeze counter is loaded with `FREEZE_FRAMES`.
  - The hit counter selected by `dead_in` increments, saturating at 15.
- **During freeze:** the counter decrements on each `nf_in`, and fire requests are ignored. A new nonzero `dead_in` reloads the counter and counts another hit.
- **Priority:** hit handling > freeze > per-channel FSM.
- **Reset values:** all bullet outputs NEUTRAL, `ready_out` = 3'b111, `frozen_out` = 0, hit counters 0, all channels IDLE. Reset mid-operation abandons any ARMED command immediately.

## Timing
- All outputs are registered.
- State changes happen only on `clk_in` edges where `nf_in` = 1. The exceptions are the facing, edge and pending registers, which update every cycle.
- A command is set on frame tick N and held through tick N+1. The manager samples it at tick N+1, seeing the pre-edge value. Exactly one frame of non-NEUTRAL per shot.
- **Earliest refire:** a shot ARMED at tick N can next be ARMED at tick N + `COOLDOWN_FRAMES` + 2.
- `ready_out` and `frozen_out` update in the same cycle as the state change that drives them.

## Structure
- **Shared package `bullet_pkg`:**
  - Direction localparams NEUTRAL=0, RIGHT=1, LEFT=2, UP=3, DOWN=4.
  - `dir_t` as `logic [2:0]`.
  - `chan_state_t` enum {IDLE, ARMED, COOLDOWN}.
  - `BOX_DIM` = 90.
- **Sub-module `fire_channel`:** instantiated three times. It contains the facing register, edge detector, pending flag, FSM and cooldown counter, and takes `frozen` and `flush` inputs.
- **Top level:** the freeze counter, hit counters and `dead_in` decode.

## Test plan
- **Basic fire:** reset, b facing RIGHT, pulse `fire_in[0]` 3 cycles before tick 1 → `b_bullet_out` = 1 from tick 1 to tick 2, then 0, with `ready_out[0]` = 0 from tick 1 through tick 5.
- **Refire blocked:** with `COOLDOWN_FRAMES`=4, fire at tick 1, then press before each of ticks 2..6 → only the tick-7 press arms; `b_bullet_out` = 0 on ticks 2..6.
- **Facing update:** set `c_dir_in` = 3, then 0, then 6 → c fires UP (3); a 0 or 6 direction never yields an illegal command.
- **Hit freeze:** `dead_in` = 2 at tick 10 while d is ARMED → `d_bullet_out` = 0 at tick 10, `c_hits_out` = 1, `frozen_out` = 1 for 8 ticks, and fire presses during ticks 10..17 produce no command.
- **Simultaneous events:** a fire edge and `dead_in` = 1 on the same tick → no command, `b_hits_out` increments. Sixteen hits on b → `b_hits_out` stays 15.
- **Async reset:** assert `rst_in` low mid-cycle while b is ARMED → `b_bullet_out` = 0 immediately without a clock, and all channels are IDLE after release.
